// File: rtl/lfsr_random_source.sv
// lfsr_random_source
//   Free-running Fibonacci LFSR with runtime reseed and zero-lockup recovery.
//   It also serves bounded random numbers in [0, max_val] over a req/busy/out_valid
//   handshake, using masked rejection sampling.
//
//   Optional feature macro: RNG_ENTROPY_EN
//     When defined, the design has an extra 1-bit input entropy_in. That input is
//     XORed into the LFSR feedback, so the sequence stops being deterministic. It
//     can then reach the all-zero state, and the zero-guard pulls it back out.
//     When undefined, the port is absent. The sequence is then fully
//     deterministic, with period 2^WIDTH-1 for a maximal TAPS mask.
module lfsr_random_source #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [WIDTH-1:0] max_val,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] random_out
`ifdef RNG_ENTROPY_EN
  ,
  input  logic             entropy_in
`endif
);

  // Elaboration-time sanity on the configuration
  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_random_source: WIDTH must be in 3..32");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_random_source: SEED must be non-zero");
  end

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SEARCH = 1'b1;

  // Smallest 2^k-1 covering v. Each bit is set when v has any 1 at or above it.
  function automatic logic [WIDTH-1:0] cover_mask(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] m;
    m[WIDTH-1] = v[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      m[i] = m[i+1] | v[i];
    end
    return m;
  endfunction

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] max_lat_q, max_lat_d;
  logic [WIDTH-1:0] mask_lat_q, mask_lat_d;
  logic [WIDTH-1:0] random_out_q, random_out_d;
  logic             out_valid_q, out_valid_d;

  logic             fb;
  logic [WIDTH-1:0] cand;
  logic             cand_ok;

  // Feedback bit: parity of the tapped bits, optionally perturbed by external entropy
  always_comb begin
`ifdef RNG_ENTROPY_EN
    fb = (^(lfsr_q & TAPS)) ^ entropy_in;
`else
    fb = ^(lfsr_q & TAPS);
`endif
  end

  // LFSR next state: an explicit reseed beats lockup recovery, which beats a normal shift
  always_comb begin
    lfsr_d = {lfsr_q[WIDTH-2:0], fb};
    if (seed_load) begin
      lfsr_d = (seed_in == '0) ? SEED : seed_in;
    end else if (lfsr_q == '0) begin
      lfsr_d = SEED;
    end
  end

  // Candidate sample: the masked current LFSR value, accepted if it does not exceed the bound
  always_comb begin
    cand    = lfsr_q & mask_lat_q;
    cand_ok = (cand <= max_lat_q);
  end

  // Request FSM: latch the bound and its mask on accept, then draw until a candidate fits
  always_comb begin
    state_d      = state_q;
    max_lat_d    = max_lat_q;
    mask_lat_d   = mask_lat_q;
    random_out_d = random_out_q;
    out_valid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          max_lat_d  = max_val;
          mask_lat_d = cover_mask(max_val);
          state_d    = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (cand_ok) begin
          random_out_d = cand;
          out_valid_d  = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // LFSR register: runs every cycle, independent of the request FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // FSM and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      max_lat_q    <= '0;
      mask_lat_q   <= '0;
      random_out_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      max_lat_q    <= max_lat_d;
      mask_lat_q   <= mask_lat_d;
      random_out_q <= random_out_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign busy       = (state_q == ST_SEARCH);
  assign out_valid  = out_valid_q;
  assign random_out = random_out_q;

`ifndef SYNTHESIS
  // The result cycle is always an IDLE cycle
  a_valid_not_busy: assert property (@(posedge clk) disable iff (rst)
    out_valid_q |-> !busy);
  // The latched mask always covers the latched bound, so every search can terminate
  a_mask_covers: assert property (@(posedge clk) disable iff (rst)
    busy |-> (mask_lat_q >= max_lat_q));
`ifndef RNG_ENTROPY_EN
  // Without entropy the register can never reach zero
  a_never_zero: assert property (@(posedge clk) disable iff (rst)
    lfsr_q != '0);
`endif
`endif

endmodule

// File: tb/tb_lfsr_random_source.sv
// Self-checking bench for lfsr_random_source (default build, RNG_ENTROPY_EN undefined).
// A reference LFSR follows the DUT's LFSR. When a request is accepted, the bench
// predicts the returned value and latency and pushes them onto a scoreboard queue.
// The entry is popped and compared when out_valid is due.
module tb_lfsr_random_source;

  localparam logic [7:0] SEED = 8'hA5;
  localparam logic [7:0] TAPS = 8'hB8;

  typedef struct {
    logic [7:0] value;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [7:0] max_val;
  logic       seed_load;
  logic [7:0] seed_in;
  logic       busy;
  logic       out_valid;
  logic [7:0] random_out;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  int   elapsed;
  logic [7:0] m_lfsr;
  logic [7:0] m_rand;
  bit   count_mode = 1'b0;
  int   hist[10];
  int   n_done;
  int   rej_total;
  int   busy_cycles;

  always #5 clk = ~clk;

  lfsr_random_source #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .max_val   (max_val),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .busy      (busy),
    .out_valid (out_valid),
    .random_out(random_out)
  );

  // Reference feedback: parity of tapped bits, shifted in at the LSB
  function automatic logic [7:0] model_step(input logic [7:0] s);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) if (TAPS[i]) p = p ^ s[i];
    return {s[6:0], p};
  endfunction

  // Reference mask: grow 2^k-1 until it reaches the bound
  function automatic logic [7:0] ref_mask(input logic [7:0] mv);
    int unsigned m;
    m = 0;
    while (m < mv) m = m * 2 + 1;
    return m[7:0];
  endfunction

  // Predict the result of a request accepted when the LFSR holds 'start' after the accept edge
  task automatic predict(input logic [7:0] mv, input logic [7:0] start);
    logic [7:0] mk;
    logic [7:0] s;
    int         lat;
    exp_t       e;
    mk  = ref_mask(mv);
    s   = start;
    lat = 2;
    while (((s & mk) > mv) && lat < 300) begin
      s   = model_step(s);
      lat = lat + 1;
    end
    e.value = s & mk;
    e.lat   = lat;
    sb.push_back(e);
  endtask

  // One clock edge. Outputs are sampled 1 time unit after posedge, and the model advances with them.
  task automatic cycle();
    bit         accept;
    logic [7:0] mv_s;
    bit         sl;
    logic [7:0] si;
    accept = req && (sb.size() == 0);
    mv_s   = max_val;
    sl     = seed_load;
    si     = seed_in;
    @(posedge clk);
    #1;
    if (sl) m_lfsr = (si == 8'h00) ? SEED : si;
    else if (m_lfsr == 8'h00) m_lfsr = SEED;
    else m_lfsr = model_step(m_lfsr);
    checks++;
    if (dut.lfsr_q !== m_lfsr) begin
      failures++;
      $display("FAIL lfsr_track: got %h expected %h", dut.lfsr_q, m_lfsr);
    end
    if (count_mode && busy === 1'b1 && out_valid === 1'b0) busy_cycles++;
    if (sb.size() > 0) begin
      elapsed++;
      if (elapsed == sb[0].lat) begin
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b0) begin
          failures++;
          $display("FAIL done_handshake: out_valid=%b busy=%b expected 1/0 at edge %0d", out_valid, busy, elapsed);
        end
        checks++;
        if (random_out !== sb[0].value) begin
          failures++;
          $display("FAIL result_value: got %h expected %h", random_out, sb[0].value);
        end
        m_rand = sb[0].value;
        if (count_mode) begin
          n_done++;
          rej_total = rej_total + (sb[0].lat - 2);
          if (random_out <= 8'd9) hist[random_out]++;
          checks++;
          if (random_out > 8'd9) begin
            failures++;
            $display("FAIL bound_9: got %0d expected <= 9", random_out);
          end
          checks++;
          if (elapsed > 32) begin
            failures++;
            $display("FAIL latency_bound: got %0d edges expected <= 32", elapsed);
          end
        end
        void'(sb.pop_front());
      end else begin
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || random_out !== m_rand) begin
          failures++;
          $display("FAIL search_state: busy=%b out_valid=%b random_out=%h expected 1/0/%h",
                   busy, out_valid, random_out, m_rand);
        end
      end
    end else if (accept) begin
      predict(mv_s, m_lfsr);
      elapsed = 1;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL accept_busy: busy=%b out_valid=%b expected 1/0", busy, out_valid);
      end
    end else begin
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || random_out !== m_rand) begin
        failures++;
        $display("FAIL idle_state: busy=%b out_valid=%b random_out=%h expected 0/0/%h",
                 busy, out_valid, random_out, m_rand);
      end
    end
  endtask

  // Pulse req for one cycle, then run until the scoreboard drains or a bound expires
  task automatic do_request(input logic [7:0] mv);
    int n;
    req     = 1'b1;
    max_val = mv;
    cycle();
    req = 1'b0;
    n   = 0;
    while (sb.size() > 0 && n < 64) begin
      cycle();
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL request_timeout: max_val=%h still pending after %0d cycles, required completion", mv, n);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req       = 1'b0;
    max_val   = 8'h00;
    seed_load = 1'b0;
    seed_in   = 8'h00;
    @(posedge clk);
    #1;
    sb.delete();
    m_lfsr = SEED;
    m_rand = 8'h00;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || random_out !== 8'h00 || dut.lfsr_q !== SEED) begin
      failures++;
      $display("FAIL reset_state: busy=%b out_valid=%b random_out=%h lfsr=%h expected 0/0/00/a5",
               busy, out_valid, random_out, dut.lfsr_q);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_request();
    req     = 1'b1;
    max_val = 8'hFF;
    cycle();
    req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL first_busy: got %b expected 1", busy);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b1 || random_out !== 8'h4A) begin
      failures++;
      $display("FAIL first_value: out_valid=%b random_out=%h expected 1/4a", out_valid, random_out);
    end
  endtask

  task automatic test_free_run();
    bit seen[256];
    int distinct;
    bit zero_seen;
    distinct  = 0;
    zero_seen = 1'b0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 255; i++) begin
      cycle();
      if (dut.lfsr_q == 8'h00) zero_seen = 1'b1;
      if (!seen[dut.lfsr_q]) distinct++;
      seen[dut.lfsr_q] = 1'b1;
    end
    checks++;
    if (dut.lfsr_q !== SEED) begin
      failures++;
      $display("FAIL period_return: got %h expected a5", dut.lfsr_q);
    end
    checks++;
    if (zero_seen || distinct != 255) begin
      failures++;
      $display("FAIL period_coverage: zero_seen=%b distinct=%0d expected 0/255", zero_seen, distinct);
    end
  endtask

  task automatic test_zero_max();
    req     = 1'b1;
    max_val = 8'h00;
    cycle();
    req = 1'b0;
    cycle();
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || random_out !== 8'h00) begin
      failures++;
      $display("FAIL zero_max: out_valid=%b busy=%b random_out=%h expected 1/0/00", out_valid, busy, random_out);
    end
  endtask

  task automatic test_patterns();
    logic [7:0] pats[7];
    pats = '{8'h01, 8'h10, 8'h80, 8'hFE, 8'hFF, 8'h09, 8'h03};
    for (int i = 0; i < 7; i++) begin
      do_request(pats[i]);
      cycle();
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    req     = 1'b1;
    max_val = 8'h09;
    cycle();
    max_val = 8'h00;
    n = 0;
    while (sb.size() > 0 && n < 64) begin
      cycle();
      n++;
    end
    req = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL busy_ignore_timeout: pending=%0d expected 0", sb.size());
      sb.delete();
    end
    cycle();
  endtask

  task automatic test_seed();
    seed_load = 1'b1;
    seed_in   = 8'h00;
    cycle();
    seed_load = 1'b0;
    checks++;
    if (dut.lfsr_q !== 8'hA5) begin
      failures++;
      $display("FAIL seed_zero: got %h expected a5", dut.lfsr_q);
    end
    seed_load = 1'b1;
    seed_in   = 8'h01;
    cycle();
    seed_load = 1'b0;
    req       = 1'b1;
    max_val   = 8'hFF;
    cycle();
    req = 1'b0;
    cycle();
    checks++;
    if (out_valid !== 1'b1 || random_out !== 8'h02) begin
      failures++;
      $display("FAIL seed_value: out_valid=%b random_out=%h expected 1/02", out_valid, random_out);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit all_seen;
    for (int i = 0; i < 10; i++) hist[i] = 0;
    n_done      = 0;
    rej_total   = 0;
    busy_cycles = 0;
    count_mode  = 1'b1;
    req         = 1'b1;
    max_val     = 8'h09;
    cyc         = 0;
    while (n_done < 1000 && cyc < 20000) begin
      cycle();
      cyc++;
    end
    req        = 1'b0;
    count_mode = 1'b0;
    cyc        = 0;
    while (sb.size() > 0 && cyc < 64) begin
      cycle();
      cyc++;
    end
    sb.delete();
    checks++;
    if (n_done != 1000) begin
      failures++;
      $display("FAIL bulk_count: got %0d completions expected 1000", n_done);
    end
    all_seen = 1'b1;
    for (int i = 0; i < 10; i++) if (hist[i] == 0) all_seen = 1'b0;
    checks++;
    if (!all_seen) begin
      failures++;
      $display("FAIL bulk_coverage: some value in 0..9 never returned, required all");
    end
    checks++;
    if (busy_cycles != rej_total + n_done) begin
      failures++;
      $display("FAIL bulk_busy_cycles: got %0d expected %0d", busy_cycles, rej_total + n_done);
    end
  endtask

  task automatic test_reset_mid_search();
    int bad;
    seed_load = 1'b1;
    seed_in   = 8'h0E;
    cycle();
    seed_load = 1'b0;
    req       = 1'b1;
    max_val   = 8'h09;
    cycle();
    req = 1'b0;
    cycle();
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    m_lfsr = SEED;
    m_rand = 8'h00;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || random_out !== 8'h00 || dut.lfsr_q !== SEED) begin
      failures++;
      $display("FAIL async_reset: busy=%b out_valid=%b random_out=%h lfsr=%h expected 0/0/00/a5",
               busy, out_valid, random_out, dut.lfsr_q);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_hold: %0d cycles with out_valid/busy set, required 0", bad);
    end
    rst = 1'b0;
    test_first_request();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_request();
    test_reset();
    test_free_run();
    test_zero_max();
    test_patterns();
    test_busy_ignore();
    test_seed();
    test_back_to_back();
    test_reset_mid_search();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
